// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory behind the MEM stage.
// Accepts one load/store at a time over valid/ready, holds it for a fixed
// latency, then returns a registered one-cycle response. The array access
// happens on the edge that enters the response state, so a store followed
// by a load to the same word needs no bypass.
module dmem_responder #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  // Number of WAIT cycles between accept and the response cycle.
  localparam logic [3:0] LatLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic                    misal_q, misal_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    enter_resp;

  logic                    resp_valid_q;
  logic [DATA_W-1:0]       resp_rdata_q;
  logic                    resp_err_q;

  logic [DATA_W-1:0]       mem [Depth];

  // Upper address bits are ignored: accesses wrap modulo the depth.
  logic unused_addr;
  assign unused_addr = ^req_addr[ADDR_W-1:DEPTH_LOG2+3];

  // Next-state, counter and request capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    misal_d    = misal_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          misal_d = |req_addr[2:0];
          idx_d   = req_addr[DEPTH_LOG2+2:3];
          wdata_d = req_wdata;
          cnt_d   = LatLoad;
          state_d = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        // The decrement that reaches zero is also the edge that enters RESP.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The _d capture values hold the access being issued; with LATENCY=1 they
  // come straight from the request inputs on the accept edge.
  assign enter_resp = (state_d == StResp);

  // State, counter and captured request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      misal_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      misal_q <= misal_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (enter_resp && write_d && !misal_d) begin
      mem[idx_d] <= wdata_d;
    end
  end

  // Registered response; data and error are zero outside the RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= enter_resp;
      resp_err_q   <= enter_resp && misal_d;
      resp_rdata_q <= (enter_resp && !write_d && !misal_d) ? mem[idx_d] : '0;
    end
  end

  // Handshake and pipeline hold; stall is forced low while reset is asserted.
  always_comb begin
    req_ready  = (state_q == StIdle);
    stall      = rst && (((state_q == StIdle) && req_valid) || (state_q == StWait));
    resp_valid = resp_valid_q;
    resp_rdata = resp_rdata_q;
    resp_err   = resp_err_q;
  end

endmodule
